// File: rtl/sctag_evict_rdseq.sv
// Eviction read sequencer: issues NUM_DWORDS dword reads per writeback entry,
// gathers the r5 ECC flags and reports completion to the writeback queue.
module sctag_evict_rdseq #(
    parameter int NUM_DWORDS = 8,
    parameter int DW_W       = 3,
    parameter int WL_W       = 3,
    parameter int ERR_LAT    = 5
) (
    input  logic            rclk,
    input  logic            arst_l,
    input  logic            evq_req_vld,
    input  logic [WL_W-1:0] evq_req_wl,
    output logic            evq_req_rdy,
    input  logic            ev_stall,
    output logic            sctag_scbuf_evict_en_r0,
    output logic [DW_W-1:0] sctag_scbuf_ev_dword_r0,
    input  logic            scbuf_sctag_ev_uerr_r5,
    input  logic            scbuf_sctag_ev_cerr_r5,
    output logic            evict_done,
    output logic [WL_W-1:0] evict_done_wl,
    output logic            evict_uerr,
    output logic            evict_cerr
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    localparam logic [DW_W-1:0] LAST_DW = DW_W'(NUM_DWORDS - 1);
    localparam logic [DW_W:0]   LAST_RX = (DW_W + 1)'(NUM_DWORDS - 1);

    state_t             state;
    logic [DW_W-1:0]    cnt;
    logic [DW_W:0]      rx;
    logic [WL_W-1:0]    wl_q;
    logic               sticky_u;
    logic               sticky_c;
    logic [ERR_LAT-1:0] vld_pipe;
    logic               r5_vld;

    assign evq_req_rdy             = (state == IDLE) & arst_l;
    assign sctag_scbuf_evict_en_r0 = (state == ISSUE) & ~ev_stall;
    assign sctag_scbuf_ev_dword_r0 = (state == ISSUE) ? cnt : '0;
    assign evict_done              = (state == DONE);
    assign evict_done_wl           = evict_done ? wl_q : '0;
    assign evict_uerr              = evict_done & sticky_u;
    assign evict_cerr              = evict_done & sticky_c;

    // Top of the pipe marks the r5 return slot of a strobe issued ERR_LAT cycles ago.
    assign r5_vld = vld_pipe[ERR_LAT-1];

    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            state    <= IDLE;
            cnt      <= '0;
            rx       <= '0;
            wl_q     <= '0;
            sticky_u <= 1'b0;
            sticky_c <= 1'b0;
            vld_pipe <= '0;
        end else begin
            vld_pipe <= (vld_pipe << 1) | ERR_LAT'(sctag_scbuf_evict_en_r0);
            if (r5_vld) begin
                sticky_u <= sticky_u | scbuf_sctag_ev_uerr_r5;
                sticky_c <= sticky_c | scbuf_sctag_ev_cerr_r5;
                rx       <= rx + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (evq_req_vld) begin
                        wl_q     <= evq_req_wl;
                        cnt      <= '0;
                        rx       <= '0;
                        sticky_u <= 1'b0;
                        sticky_c <= 1'b0;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (sctag_scbuf_evict_en_r0) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST_DW) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (r5_vld && rx == LAST_RX) state <= DONE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sctag_evict_rdseq.sv
// Directed bench for sctag_evict_rdseq: transaction-level model checked every cycle,
// plus literal timing/status expectations per scenario.
module tb_sctag_evict_rdseq;
    localparam int N   = 8;
    localparam int LAT = 5;

    logic       rclk = 1'b0;
    logic       arst_l = 1'b0;
    logic       evq_req_vld = 1'b0;
    logic [2:0] evq_req_wl = 3'd0;
    logic       evq_req_rdy;
    logic       ev_stall = 1'b0;
    logic       en;
    logic [2:0] dw;
    logic       uerr = 1'b0;
    logic       cerr = 1'b0;
    logic       done;
    logic [2:0] done_wl;
    logic       ev_u;
    logic       ev_c;

    always #5 rclk = ~rclk;

    sctag_evict_rdseq #(.NUM_DWORDS(N), .DW_W(3), .WL_W(3), .ERR_LAT(LAT)) dut (
        .rclk(rclk), .arst_l(arst_l),
        .evq_req_vld(evq_req_vld), .evq_req_wl(evq_req_wl), .evq_req_rdy(evq_req_rdy),
        .ev_stall(ev_stall),
        .sctag_scbuf_evict_en_r0(en), .sctag_scbuf_ev_dword_r0(dw),
        .scbuf_sctag_ev_uerr_r5(uerr), .scbuf_sctag_ev_cerr_r5(cerr),
        .evict_done(done), .evict_done_wl(done_wl),
        .evict_uerr(ev_u), .evict_cerr(ev_c)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // transaction model: busy flag, issued count, queue of issue cycles awaiting r5
    bit         m_busy = 0, m_done = 0, m_u = 0, m_c = 0;
    int         m_issued = 0, m_rx = 0;
    logic [2:0] m_wl = 3'd0;
    int         m_q[$];

    // observations of the DUT, used by the literal expectations
    int          acc_q[$];
    int          dn_q[$];
    logic [2:0]  dn_wl_q[$];
    bit          dn_u_q[$];
    bit          dn_c_q[$];
    logic [63:0] en_mask = '0;
    logic [31:0] dw_log = '0;
    int          en_cnt = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    always @(negedge rclk) begin
        logic [10:0] act, exp;
        bit e_rdy, e_en, e_iss;
        int d;
        act = {evq_req_rdy, en, dw, done, done_wl, ev_u, ev_c};
        if (!arst_l) begin
            exp = '0;
            m_busy = 0; m_done = 0; m_issued = 0; m_rx = 0;
            m_q.delete();
        end else begin
            e_iss = m_busy && !m_done && (m_issued < N);
            e_rdy = !m_busy;
            e_en  = e_iss && !ev_stall;
            exp = {e_rdy, e_en, (e_iss ? 3'(m_issued) : 3'd0), m_done,
                   (m_done ? m_wl : 3'd0), m_done & m_u, m_done & m_c};
            if (m_done) begin
                m_busy = 0; m_done = 0;
            end else if (e_rdy && evq_req_vld) begin
                m_busy = 1; m_issued = 0; m_rx = 0; m_u = 0; m_c = 0; m_wl = evq_req_wl;
            end
            if (e_en) begin
                m_q.push_back(cyc);
                m_issued++;
            end
            if (m_q.size() > 0 && m_q[0] + LAT == cyc) begin
                void'(m_q.pop_front());
                m_u = m_u | uerr;
                m_c = m_c | cerr;
                m_rx++;
                if (m_rx == N) m_done = 1;
            end
        end
        chk($sformatf("outs@%0d", cyc), 64'(act), 64'(exp));

        if (evq_req_rdy && evq_req_vld) acc_q.push_back(cyc);
        if (en) begin
            en_cnt++;
            dw_log = {dw_log[27:0], 1'b0, dw};
            if (acc_q.size() > 0) begin
                d = cyc - acc_q[acc_q.size()-1];
                if (d >= 0 && d < 64) en_mask[d] = 1'b1;
            end
        end
        if (done) begin
            dn_q.push_back(cyc);
            dn_wl_q.push_back(done_wl);
            dn_u_q.push_back(ev_u);
            dn_c_q.push_back(ev_c);
        end
        cyc++;
    end

    task automatic step(int n);
        repeat (n) begin
            @(posedge rclk);
            #1;
        end
    endtask

    task automatic clr_logs();
        acc_q.delete(); dn_q.delete(); dn_wl_q.delete(); dn_u_q.delete(); dn_c_q.delete();
        en_mask = '0; dw_log = '0; en_cnt = 0;
    endtask

    task automatic req(logic [2:0] wl);
        evq_req_vld = 1'b1;
        evq_req_wl  = wl;
        step(1);
        evq_req_vld = 1'b0;
    endtask

    task automatic wait_done(int n, int lim);
        int k = 0;
        while (dn_q.size() < n && k < lim) begin
            step(1);
            k++;
        end
        chk("done_timeout", 64'(dn_q.size()), 64'(n));
    endtask

    initial begin
        step(3);
        chk("rst_outs", 64'({evq_req_rdy, en, dw, done, done_wl, ev_u, ev_c}), 64'd0);
        arst_l = 1'b1;
        step(2);

        // plain eviction
        clr_logs(); req(3'd5); wait_done(1, 40);
        chk("t1_rdy_back", 64'(evq_req_rdy), 64'd1);
        if (dn_q.size() > 0) begin
            chk("t1_lat", 64'(dn_q[0] - acc_q[0]), 64'd14);
            chk("t1_wl", 64'(dn_wl_q[0]), 64'd5);
            chk("t1_err", 64'({dn_u_q[0], dn_c_q[0]}), 64'd0);
        end
        chk("t1_mask", en_mask, 64'h1fe);
        chk("t1_dw", 64'(dw_log), 64'h01234567);

        // stall T+3..T+5
        clr_logs(); req(3'd2); step(2);
        ev_stall = 1'b1; step(3); ev_stall = 1'b0;
        wait_done(1, 40);
        chk("t2_mask", en_mask, 64'hfc6);
        chk("t2_dw", 64'(dw_log), 64'h01234567);
        if (dn_q.size() > 0) chk("t2_lat", 64'(dn_q[0] - acc_q[0]), 64'd17);

        // cerr on dword 2, uerr on dword 7, junk uerr at T+2
        clr_logs(); req(3'd3); step(1);
        uerr = 1'b1; step(1); uerr = 1'b0;
        step(5); cerr = 1'b1; step(1); cerr = 1'b0;
        step(4); uerr = 1'b1; step(1); uerr = 1'b0;
        wait_done(1, 40);
        if (dn_q.size() > 0) begin
            chk("t3_err", 64'({dn_u_q[0], dn_c_q[0]}), 64'b11);
            chk("t3_lat", 64'(dn_q[0] - acc_q[0]), 64'd14);
        end

        // junk uerr only
        clr_logs(); req(3'd3); step(1);
        uerr = 1'b1; step(1); uerr = 1'b0;
        wait_done(1, 40);
        if (dn_q.size() > 0) chk("t3_junk_err", 64'({dn_u_q[0], dn_c_q[0]}), 64'b00);

        // uerr and cerr together on dword 0
        clr_logs(); req(3'd4); step(5);
        uerr = 1'b1; cerr = 1'b1; step(1); uerr = 1'b0; cerr = 1'b0;
        wait_done(1, 40);
        if (dn_q.size() > 0) chk("t3_both_err", 64'({dn_u_q[0], dn_c_q[0]}), 64'b11);

        // back-to-back with vld held; first eviction sees a uerr
        clr_logs();
        evq_req_vld = 1'b1; evq_req_wl = 3'd1; step(1);
        evq_req_wl = 3'd6; step(5);
        uerr = 1'b1; step(1); uerr = 1'b0;
        wait_done(2, 60);
        evq_req_vld = 1'b0;
        chk("t4_accepts", 64'(acc_q.size()), 64'd2);
        if (acc_q.size() == 2 && dn_q.size() == 2) begin
            chk("t4_acc_gap", 64'(acc_q[1] - acc_q[0]), 64'd15);
            chk("t4_done2", 64'(dn_q[1] - acc_q[0]), 64'd29);
            chk("t4_wl", 64'({dn_wl_q[0], dn_wl_q[1]}), 64'({3'd1, 3'd6}));
            chk("t4_uerr", 64'({dn_u_q[0], dn_u_q[1]}), 64'b10);
        end
        step(2);

        // reset mid-eviction, then a fresh request
        clr_logs(); req(3'd5); step(5);
        arst_l = 1'b0; step(1);
        chk("t5_rst_outs", 64'({evq_req_rdy, en, dw, done, done_wl, ev_u, ev_c}), 64'd0);
        step(1);
        arst_l = 1'b1; evq_req_vld = 1'b1; evq_req_wl = 3'd2; step(1);
        evq_req_vld = 1'b0; uerr = 1'b1; cerr = 1'b1; step(4);
        uerr = 1'b0; cerr = 1'b0;
        wait_done(1, 40);
        chk("t5_accepts", 64'(acc_q.size()), 64'd2);
        if (dn_q.size() > 0 && acc_q.size() == 2) begin
            chk("t5_wl", 64'(dn_wl_q[0]), 64'd2);
            chk("t5_err", 64'({dn_u_q[0], dn_c_q[0]}), 64'd0);
            chk("t5_lat", 64'(dn_q[0] - acc_q[1]), 64'd14);
        end
        step(3);
        chk("t5_done_cnt", 64'(dn_q.size()), 64'd1);

        // idle with toggling error inputs
        clr_logs();
        for (int i = 0; i < 20; i++) begin
            uerr = i[0]; cerr = i[1];
            step(1);
        end
        uerr = 1'b0; cerr = 1'b0;
        chk("t6_en_cnt", 64'(en_cnt), 64'd0);
        chk("t6_done_cnt", 64'(dn_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
